trace_trig_seq: RTL

TRACE_TRIG_SEQ -- requirements
Module: trace_trig_seq

---
 rtl/trace_trig_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/trace_trig_seq.sv
// Trace trigger sequencer: resync the trace trigger, wait for decoder sync,
// then count rising-edge rule matches until the target count is reached.
module trace_trig_seq #(
    parameter int pMATCH_RULES   = 8,
    parameter int pRESYNC_CYCLES = 4,
    parameter int pSYNC_TIMEOUT  = 50000
) (
    input  logic                    usb_clk,
    input  logic                    reset_i,
    input  logic                    I_arm,
    input  logic                    I_abort,
    input  logic [7:0]              I_match_target,
    input  logic [pMATCH_RULES-1:0] I_pattern_enable,
    input  logic [pMATCH_RULES-1:0] I_matching_pattern,
    input  logic                    I_synchronized,
    output logic                    O_trace_reset_sync,
    output logic                    O_trace_trig_enable,
    output logic [2:0]              O_state,
    output logic [7:0]              O_match_count,
    output logic [2:0]              O_first_rule,
    output logic                    O_done,
    output logic                    O_timeout
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESYNC    = 3'd1,
        WAIT_SYNC = 3'd2,
        ARMED     = 3'd3,
        DONE      = 3'd4,
        ERROR     = 3'd5
    } state_t;

    localparam logic [7:0]  RS_LAST = 8'(pRESYNC_CYCLES - 1);
    localparam logic [15:0] TO_LAST = 16'(pSYNC_TIMEOUT - 1);

    state_t                  state;
    logic [7:0]              rs_cnt;
    logic [15:0]             to_cnt;
    logic                    hist;
    logic [pMATCH_RULES-1:0] masked;
    logic                    hit;
    logic                    match_ev;
    logic [7:0]              cnt_inc;
    logic [7:0]              target;
    logic                    complete;
    logic [2:0]              low_idx;

    assign O_state = state;

    always_comb begin
        masked   = I_matching_pattern & I_pattern_enable;
        hit      = |masked;
        match_ev = hit & ~hist;
        cnt_inc  = (O_match_count == 8'hFF) ? 8'hFF : O_match_count + 8'd1;
        target   = (I_match_target == 8'd0) ? 8'd1 : I_match_target;
        complete = match_ev && (cnt_inc == target);
    end

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        low_idx = 3'd0;
        for (int i = pMATCH_RULES - 1; i >= 0; i--) begin
            if (masked[i]) low_idx = 3'(i);
        end
    end

    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) begin
            state               <= IDLE;
            rs_cnt              <= 8'd0;
            to_cnt              <= 16'd0;
            hist                <= 1'b0;
            O_trace_reset_sync  <= 1'b0;
            O_trace_trig_enable <= 1'b0;
            O_match_count       <= 8'd0;
            O_first_rule        <= 3'd0;
            O_done              <= 1'b0;
            O_timeout           <= 1'b0;
        end else if (I_abort) begin
            state               <= IDLE;
            O_trace_reset_sync  <= 1'b0;
            O_trace_trig_enable <= 1'b0;
            O_done              <= 1'b0;
            O_timeout           <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE, ERROR: begin
                    if (I_arm) begin
                        state              <= RESYNC;
                        O_trace_reset_sync <= 1'b1;
                        rs_cnt             <= 8'd0;
                        O_match_count      <= 8'd0;
                        O_first_rule       <= 3'd0;
                        O_done             <= 1'b0;
                        O_timeout          <= 1'b0;
                    end
                end
                RESYNC: begin
                    if (rs_cnt == RS_LAST) begin
                        state              <= WAIT_SYNC;
                        O_trace_reset_sync <= 1'b0;
                        to_cnt             <= 16'd0;
                    end else begin
                        rs_cnt <= rs_cnt + 8'd1;
                    end
                end
                WAIT_SYNC: begin
                    if (I_synchronized) begin
                        state               <= ARMED;
                        O_trace_trig_enable <= 1'b1;
                        hist                <= 1'b0;
                    end else if (to_cnt == TO_LAST) begin
                        state     <= ERROR;
                        O_timeout <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                ARMED: begin
                    hist <= hit;
                    if (match_ev) begin
                        O_match_count <= cnt_inc;
                        if (O_match_count == 8'd0) O_first_rule <= low_idx;
                    end
                    // A completing match outranks a simultaneous sync loss.
                    if (complete) begin
                        state               <= DONE;
                        O_done              <= 1'b1;
                        O_trace_trig_enable <= 1'b0;
                    end else if (!I_synchronized) begin
                        state               <= ERROR;
                        O_timeout           <= 1'b1;
                        O_trace_trig_enable <= 1'b0;
                    end
                end
                default: begin
                    state               <= IDLE;
                    O_trace_reset_sync  <= 1'b0;
                    O_trace_trig_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule
